// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares one single-port, negedge-registered word RAM
// between an instruction-fetch port (F, read-only) and a load/store port (D).
module ram_arbiter #(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_BITS   = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic        f_err,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        ram_read_enable,
  output logic        ram_write_enable,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES);
  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_q, grant_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           f_ack_q, f_ack_d, f_err_q, f_err_d;
  logic           d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0]    f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic           ram_re_q, ram_re_d, ram_we_q, ram_we_d;
  logic [31:0]    ram_addr_q, ram_addr_d, ram_din_q, ram_din_d;
  logic           sel_s;
  logic [31:0]    req_addr_s;

  // Misaligned or beyond the implemented byte-address range.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [31:0] upper;
    upper = addr >> ADDR_BITS;
    return (addr[1:0] != 2'b00) || (upper != 32'd0);
  endfunction

  // Arbitration, access sequencing and response generation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wait_d       = wait_q;
    f_ack_d      = 1'b0;
    f_err_d      = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    ram_re_d     = ram_re_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    // With both requesting, the port not served last wins.
    sel_s        = (f_req && d_req) ? ~last_grant_q : d_req;
    req_addr_s   = sel_s ? d_addr : f_addr;

    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          grant_d      = sel_s;
          last_grant_d = sel_s;
          if (addr_bad(req_addr_s)) begin
            state_d = RESPOND;
            f_ack_d = ~sel_s;
            f_err_d = ~sel_s;
            d_ack_d = sel_s;
            d_err_d = sel_s;
          end else begin
            state_d    = ACCESS;
            wait_d     = {WCW{1'b0}};
            ram_addr_d = {req_addr_s[31:2], 2'b00};
            if (sel_s && d_we) begin
              ram_we_d  = 1'b1;
              ram_din_d = d_wdata;
            end else begin
              ram_re_d  = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          if (ram_re_q) begin
            if (grant_q == PORT_D) begin
              d_rdata_d = ram_data_out;
            end else begin
              f_rdata_d = ram_data_out;
            end
          end else begin
            d_rdata_d = d_rdata_q;
          end
          ram_re_d = 1'b0;
          ram_we_d = 1'b0;
          f_ack_d  = (grant_q == PORT_F);
          d_ack_d  = (grant_q == PORT_D);
          state_d  = RESPOND;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        ram_re_d = 1'b0;
        ram_we_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset leaves F to win the first grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      grant_q      <= PORT_F;
      wait_q       <= {WCW{1'b0}};
      f_ack_q      <= 1'b0;
      f_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      f_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 32'd0;
      ram_din_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wait_q       <= wait_d;
      f_ack_q      <= f_ack_d;
      f_err_q      <= f_err_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      ram_re_q     <= ram_re_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
    end
  end

  assign f_ack            = f_ack_q;
  assign f_err            = f_err_q;
  assign f_rdata          = f_rdata_q;
  assign d_ack            = d_ack_q;
  assign d_err            = d_err_q;
  assign d_rdata          = d_rdata_q;
  assign ram_read_enable  = ram_re_q;
  assign ram_write_enable = ram_we_q;
  assign ram_address      = ram_addr_q;
  assign ram_data_in      = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table plus scoreboard of expected acks, with
// hand-written fairness, reset-abort and WAIT_CYCLES=2 sequences.
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic        f_ack, f_err, d_ack, d_err;
  logic [31:0] f_rdata, d_rdata;
  logic        ram_re, ram_we;
  logic [31:0] ram_addr, ram_din;
  logic [31:0] ram_dout = 32'd0;

  logic        f_req1, d_req1, d_we1;
  logic [31:0] f_addr1, d_addr1, d_wdata1;
  logic        f_ack1, f_err1, d_ack1, d_err1;
  logic [31:0] f_rdata1, d_rdata1;
  logic        ram_re1, ram_we1;
  logic [31:0] ram_addr1, ram_din1;
  logic [31:0] ram_dout1 = 32'd0;

  ram_arbiter #(.WAIT_CYCLES(0), .ADDR_BITS(18)) dut0 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .ram_read_enable(ram_re), .ram_write_enable(ram_we),
    .ram_address(ram_addr), .ram_data_in(ram_din), .ram_data_out(ram_dout)
  );

  ram_arbiter #(.WAIT_CYCLES(2), .ADDR_BITS(18)) dut1 (
    .clk(clk), .reset(reset),
    .f_req(f_req1), .f_addr(f_addr1), .f_ack(f_ack1), .f_err(f_err1), .f_rdata(f_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_err(d_err1), .d_rdata(d_rdata1),
    .ram_read_enable(ram_re1), .ram_write_enable(ram_we1),
    .ram_address(ram_addr1), .ram_data_in(ram_din1), .ram_data_out(ram_dout1)
  );

  // Negedge-registered word RAM models, preloaded on the first negedge.
  logic [31:0] mem0 [0:65535];
  logic [31:0] mem1 [0:65535];
  logic        mem_init = 1'b0;
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) begin
        mem0[i] <= 32'd0;
        mem1[i] <= 32'd0;
      end
      mem0[4]       <= 32'hDEADBEEF;
      mem0[16'hFFFF] <= 32'h0BADF00D;
      mem1[2]       <= 32'hCAFEF00D;
      mem_init      <= 1'b1;
    end else begin
      if (ram_we)  mem0[ram_addr[17:2]]  <= ram_din;
      if (ram_re)  ram_dout              <= mem0[ram_addr[17:2]];
      if (ram_we1) mem1[ram_addr1[17:2]] <= ram_din1;
      if (ram_re1) ram_dout1             <= mem1[ram_addr1[17:2]];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;   // 0 = F, 1 = D
    logic        err;
    logic [31:0] rdata;
    int          due;    // cycle the ack must appear in, -1 = unchecked
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl_f = 32'd0;
  logic [31:0] mdl_d = 32'd0;

  // Scoreboard: every ack of dut0 is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (ram_re || ram_we))
      check("both_enables", {31'd0, ram_re & ram_we}, 32'd0);
    if (!reset && (f_ack || d_ack)) begin
      check("dual_ack", {31'd0, f_ack & d_ack}, 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_ack", {30'd0, f_ack, d_ack}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("ack_port", {31'd0, d_ack}, {31'd0, mon_e.port});
        check("ack_err", {31'd0, mon_e.port ? d_err : f_err}, {31'd0, mon_e.err});
        check("ack_rdata", mon_e.port ? d_rdata : f_rdata, mon_e.rdata);
        if (mon_e.due >= 0) check("ack_latency", cyc, mon_e.due);
      end
    end
  end

  function automatic exp_t expect_of(input vec_t v, input int due);
    exp_t e;
    e.port = v.port;
    e.err  = v.err;
    e.due  = due;
    if (v.err || v.we) begin
      e.rdata = v.port ? mdl_d : mdl_f;
    end else begin
      e.rdata = v.rdata;
      if (v.port) mdl_d = v.rdata;
      else        mdl_f = v.rdata;
    end
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    int          re_n, we_n;
    logic [31:0] we_a, we_dat;
    logic        done;
    sbq.push_back(expect_of(v, cyc + (v.err ? 1 : 2)));
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    re_n = 0; we_n = 0; we_a = 32'd0; we_dat = 32'd0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ram_re) re_n++;
      if (ram_we) begin we_n++; we_a = ram_addr; we_dat = ram_din; end
      if (v.port ? d_ack : f_ack) done = 1'b1;
    end
    check("ack_timeout", {31'd0, done}, 32'd1);
    if (!done) sbq.delete();
    check("re_cycles", re_n, (v.err || v.we) ? 32'd0 : 32'd1);
    check("we_cycles", we_n, (!v.err && v.we) ? 32'd1 : 32'd0);
    if (we_n != 0) begin
      check("we_addr", we_a, {v.addr[31:2], 2'b00});
      check("we_data", we_dat, v.wdata);
    end
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  // Waits for n dut0 acks, bounded by a cycle budget.
  task automatic wait_acks(input int n, input string name);
    int got;
    got = 0;
    for (int i = 0; i < 20 * n && got < n; i++) begin
      @(negedge clk);
      if (f_ack || d_ack) got++;
    end
    check(name, got, n);
    if (got < n) sbq.delete();
  endtask

  vec_t vecs [8];
  vec_t fv, dv;
  int   t0, re_n;
  logic done;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h00000010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h00000024, 32'h12345678, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h00000024, 32'h0,        1'b0, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h00000006, 32'h0,        1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h00040000, 32'h0,        1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0003FFFC, 32'h0,        1'b0, 32'h0BADF00D};
    vecs[6] = '{1'b1, 1'b1, 32'h00000002, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h80000000, 32'h0,        1'b1, 32'h0};

    reset = 1'b1;
    f_req = 1'b0; f_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    f_req1 = 1'b0; f_addr1 = 32'd0; d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = 32'd0; d_wdata1 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {26'd0, f_ack, f_err, d_ack, d_err, ram_re, ram_we}, 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both ports requesting continuously: F, D, F, D, F, D at 3-cycle spacing.
    fv = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
    dv = '{1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h12345678};
    t0 = cyc;
    for (int i = 0; i < 6; i++)
      sbq.push_back(expect_of((i % 2 == 0) ? fv : dv, t0 + 2 + 3 * i));
    f_req = 1'b1; f_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    wait_acks(6, "fair_acks");
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0;

    // Reset during a store's ACCESS cycle, with a fetch pending alongside.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h10;
    @(negedge clk);
    check("abort_we_set", {31'd0, ram_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_enables", {30'd0, ram_re, ram_we}, 32'd0);
    check("abort_no_ack", {30'd0, f_ack, d_ack}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_f = 32'd0; mdl_d = 32'd0;
    t0 = cyc;
    sbq.push_back(expect_of(fv, t0 + 2));
    sbq.push_back(expect_of('{1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 32'h0}, t0 + 5));
    wait_acks(2, "abort_acks");
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // WAIT_CYCLES=2 instance: enable held 3 cycles, ack 4 cycles after request.
    @(posedge clk); #1;
    f_req1 = 1'b1; f_addr1 = 32'h8;
    t0 = cyc; re_n = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ram_re1) re_n++;
      if (f_ack1) begin
        done = 1'b1;
        check("w2_latency", cyc - t0, 32'd4);
        check("w2_rdata", f_rdata1, 32'hCAFEF00D);
        check("w2_err", {31'd0, f_err1}, 32'd0);
      end
    end
    check("w2_ack_seen", {31'd0, done}, 32'd1);
    check("w2_re_cycles", re_n, 32'd3);
    check("w2_d_idle", {30'd0, d_ack1, d_err1}, 32'd0);
    check("w2_d_rdata", d_rdata1, 32'd0);
    @(posedge clk); #1;
    f_req1 = 1'b0;
    repeat (3) @(posedge clk);

    check("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
